pcpi_shared_mem: RTL and testbench
==================================

# pcpi_shared_mem

Parametrised shared word memory for the PicoRV32 + vector coprocessor system. It serves `NUM_PORTS` independent valid/ready masters, such as the CPU memory port and the `picorv32_pcpi_vec` memory port, from one storage array. Requests are granted round-robin, and each access takes a programmable number of wait cycles. An out-of-range access is always completed, never left pending. The block replaces the ad-hoc per-port memory processes and generalises them in port count, depth and latency.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of request ports; port 0 is the CPU, port 1 the vector unit.
- `DEPTH_WORDS`, 256: number of 32-bit words in the array.
- `WAIT_CYCLES`, 0: extra cycles between grant and response (0..15).
- `INIT_FILE`, "": hex image loaded with `$readmemh` at time 0 when the string is non-empty.

Ports:
- `clk`, in, 1: the single clock.
- `resetn`, in, 1: synchronous, active-low reset.
- `mem_valid`, in, `NUM_PORTS`: request valid, one bit per port.
- `mem_addr`, in, `NUM_PORTS*32`: byte address; port p uses bits [32p+31:32p].
- `mem_wdata`, in, `NUM_PORTS*32`: write data.
- `mem_wstrb`, in, `NUM_PORTS*4`: byte write enables; all zero means a read.
- `mem_ready`, out, `NUM_PORTS`: one-cycle completion pulse, at most one bit set.
- `mem_rdata`, out, 32: read data, shared by all ports and valid while `mem_ready` is set.
- `mem_err`, out, 1: out-of-range flag, qualified by `mem_ready` (see Configuration).

## Operation
FSM states are IDLE, WAIT and RESP.

- **IDLE**
  - At a clock edge with `|mem_valid` set, latch the winner, its address, its write data and its write strobes.
  - If `WAIT_CYCLES==0`: perform the access and go to RESP. Otherwise load `cnt=WAIT_CYCLES-1` and go to WAIT.
- **WAIT**
  - Decrement `cnt` each cycle.
  - At the edge where `cnt==0`: perform the access and go to RESP.
- **RESP**
  - `mem_ready[winner]` is high for exactly this cycle.
  - At the next edge go to IDLE. No grant is made in RESP, so a master's still-high `valid` is never served twice.
- **Arbitration**
  - Round-robin, searching from `last_grant+1` upward with wrap-around.
  - `last_grant` resets to `NUM_PORTS-1`, so port 0 wins the first tie.
  - `last_grant` updates only on a grant.
- **Access**
  - Word index is `addr[31:2]`; `addr[1:0]` is ignored.
  - An address is in range when the index is below `DEPTH_WORDS`.
  - Read returns the old word (read-before-write); each write strobe updates its own byte lane.
- **Out of range**
  - No array write takes place.
  - `mem_rdata=0`, and the access still completes with `mem_ready`.
- **Request rule:** masters hold `valid`, `addr`, `wdata` and `wstrb` stable until they see `ready`. The latched copies make the block tolerant of changes after the grant.
- **Reset values:** `mem_ready=0`, `mem_rdata=0`, `mem_err=0`, state IDLE, `cnt=0`, `last_grant=NUM_PORTS-1`.
- **Reset mid-access:** the access is abandoned, no write takes place and no `ready` is produced. Array contents are retained.

## Timing
- Latency from a request seen at edge k while idle: `ready` is high during the cycle after edge k+`WAIT_CYCLES`.
  - With `WAIT_CYCLES=0`, `ready` follows one edge after `valid`, matching the legacy model.
- Throughput is one access per `WAIT_CYCLES+2` cycles.
- A losing port waits, worst case, (`NUM_PORTS-1`)×(`WAIT_CYCLES+2`) cycles after its first possible grant.
- A write is visible to any access granted after its RESP cycle.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `PCPI_SHMEM_ERR_RESP_EN`.
- Defined: `mem_err` is asserted together with `mem_ready` for an out-of-range access, and each such access increments a 16-bit saturating counter `err_count`, readable hierarchically.
- Undefined: `mem_err` is tied to 0 and the counter is absent. Out-of-range behaviour is otherwise identical: the access completes, `rdata=0` and no write takes place.

## Structure
- Package `pcpi_shmem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - `WAIT_CNT_W=4`;
  - function `clog2` used to size the winner index.
- One sub-module, `pcpi_rr_arbiter`.
  - Inputs: request vector, `last_grant`.
  - Outputs: grant index and a `grant_valid` flag.
  - Purely combinational; `last_grant` is held in the parent.

## Test plan
- **Single read:** `WAIT_CYCLES=0`, word 100=`0x02010201`; port 0 reads 400 → `ready[0]` one edge later, `rdata=0x02010201`, `err=0`.
- **Byte write:** port 1 writes `0xAABBCCDD` with `wstrb=4'b0101` to 800 over `0x11223344`, then reads 800 → `0x11BB33DD`.
- **Contention:** ports 0 and 1 both request from reset, `WAIT_CYCLES=2`.
  - Port 0 is served first with `ready` at edge 3.
  - Port 1's `ready` follows 4 cycles later.
  - A repeat contention is won by port 0 again, since `last_grant=1`.
- **Out of range:** read at 1024 with `DEPTH_WORDS=256` → `ready`, `rdata=0`, `err=1`, and `err_count=1` when the macro is defined. A write to 1024 leaves word 0 unchanged.
- **Reset mid-access:** `WAIT_CYCLES=3`, write issued, `resetn` low during WAIT → no `ready`, target word unchanged; after reset the same write completes normally.
- **No double service:** port 0 holds `valid` through RESP and releases it after `ready` → exactly one `ready` pulse, and a single write takes place.

Source files
------------

// File: rtl/pcpi_shared_mem_pkg.sv
// Shared types and helpers for the pcpi_shared_mem block: FSM states,
// wait-counter width, index sizing and byte-lane merging.
package pcpi_shmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } shmem_state_e;

    localparam int WAIT_CNT_W = 4;

    // Bits needed to index 'value' items, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                r[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcpi_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 with
// wrap-around and reports the first requesting port.
module pcpi_rr_arbiter
    import pcpi_shmem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_grant_valid
);

    int w_cand;

    // Walk candidates farthest-first so the nearest requester is assigned last.
    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_cand        = 0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_cand = int'(i_last_grant) + i;
            if (w_cand >= NUM_PORTS) begin
                w_cand = w_cand - NUM_PORTS;
            end else begin
                w_cand = w_cand;
            end
            if (i_req[w_cand[IDX_W-1:0]]) begin
                o_grant_idx   = w_cand[IDX_W-1:0];
                o_grant_valid = 1'b1;
            end else begin
                o_grant_valid = o_grant_valid;
            end
        end
    end

endmodule

// File: rtl/pcpi_shared_mem.sv
// Multi-port shared word memory with round-robin grant and programmable wait
// cycles. Optional error response: define PCPI_SHMEM_ERR_RESP_EN.
module pcpi_shared_mem
    import pcpi_shmem_pkg::*;
#(
    parameter int    NUM_PORTS   = 2,
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_PORTS-1:0]   mem_valid,
    input  logic [NUM_PORTS*32-1:0] mem_addr,
    input  logic [NUM_PORTS*32-1:0] mem_wdata,
    input  logic [NUM_PORTS*4-1:0] mem_wstrb,
    output logic [NUM_PORTS-1:0]   mem_ready,
    output logic [31:0]            mem_rdata,
    output logic                   mem_err
);

    localparam int IDX_W = clog2(NUM_PORTS);
    localparam int AW    = clog2(DEPTH_WORDS);

    logic [31:0]           r_mem [DEPTH_WORDS];
    shmem_state_e          r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]      r_last_grant;
    logic [IDX_W-1:0]      r_win;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [NUM_PORTS-1:0]  r_ready;
    logic [31:0]           r_rdata;

    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_valid;
    logic [IDX_W-1:0]      w_acc_port;
    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic [3:0]            w_acc_wstrb;
    logic                  w_do_access;
    logic                  w_in_range;
    logic [AW-1:0]         w_word;
    logic [31:0]           w_old;
    logic                  w_unused_addr;

    pcpi_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .i_req         (mem_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // With zero wait cycles the access happens at the grant edge, so take the
    // request straight from the ports; otherwise use the latched copy.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_port  = w_grant_idx;
            w_acc_addr  = mem_addr[{w_grant_idx, 5'd0} +: 32];
            w_acc_wdata = mem_wdata[{w_grant_idx, 5'd0} +: 32];
            w_acc_wstrb = mem_wstrb[{w_grant_idx, 2'd0} +: 4];
        end else begin
            w_acc_port  = r_win;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_wstrb = r_wstrb;
        end
    end

    assign w_do_access   = ((r_state == ST_IDLE) && w_grant_valid && (WAIT_CYCLES == 0)) ||
                           ((r_state == ST_WAIT) && (r_cnt == {WAIT_CNT_W{1'b0}}));
    assign w_in_range    = ({2'b00, w_acc_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_word        = w_acc_addr[AW+1:2];
    assign w_old         = r_mem[w_word];
    assign w_unused_addr = ^w_acc_addr[1:0];

    // Control FSM with registered ready/rdata.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {WAIT_CNT_W{1'b0}};
            r_last_grant <= IDX_W'(NUM_PORTS - 1);
            r_win        <= {IDX_W{1'b0}};
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_ready      <= {NUM_PORTS{1'b0}};
            r_rdata      <= 32'd0;
        end else begin
            r_ready <= {NUM_PORTS{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_win        <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_addr       <= w_acc_addr;
                        r_wdata      <= w_acc_wdata;
                        r_wstrb      <= w_acc_wstrb;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= WAIT_CNT_W'(WAIT_CYCLES - 1);
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == {WAIT_CNT_W{1'b0}}) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - WAIT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_do_access) begin
                r_ready <= NUM_PORTS'(1) << w_acc_port;
                r_rdata <= w_in_range ? w_old : 32'd0;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    // Storage is not reset; a write is suppressed while resetn is low.
    always_ff @(posedge clk) begin
        if (resetn && w_do_access && w_in_range && (w_acc_wstrb != 4'd0)) begin
            r_mem[w_word] <= merge_bytes(w_old, w_acc_wdata, w_acc_wstrb);
        end
    end

`ifdef PCPI_SHMEM_ERR_RESP_EN
    logic        r_err;
    logic [15:0] err_count;

    // Out-of-range flag and saturating count of such accesses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err     <= 1'b0;
            err_count <= 16'd0;
        end else if (w_do_access && !w_in_range) begin
            r_err <= 1'b1;
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_pcpi_shared_mem.sv
// Self-checking bench for pcpi_shared_mem (2 ports, 256 words, 2 wait cycles)
// against a word-array reference model with round-robin order tracking.
module tb_pcpi_shared_mem;

    localparam int NP    = 2;
    localparam int DEPTH = 256;
    localparam int WC    = 2;
`ifdef PCPI_SHMEM_ERR_RESP_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NP-1:0]     mem_valid = '0;
    logic [NP*32-1:0]  mem_addr = '0;
    logic [NP*32-1:0]  mem_wdata = '0;
    logic [NP*4-1:0]   mem_wstrb = '0;
    logic [NP-1:0]     mem_ready;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [DEPTH];
    int          lg = NP - 1;
    int          err_cnt_model = 0;
    logic [31:0] rd;

    pcpi_shared_mem #(
        .NUM_PORTS   (NP),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WC),
        .INIT_FILE   ("")
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < 32'(DEPTH);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return in_rng(a) ? model[a[9:2]] : 32'd0;
    endfunction

    // Apply the architectural effect of a completed access to the model.
    task automatic commit(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        if (!in_rng(a)) begin
            err_cnt_model++;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) model[a[9:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
        mem_addr[p*32 +: 32] = a;
        mem_wdata[p*32 +: 32] = wd;
        mem_wstrb[p*4 +: 4] = ws;
        mem_valid[p] = 1'b1;
    endtask

    task automatic single(input int p, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold, input string tag,
                          output logic [31:0] rd_o);
        int n;
        bit seen;
        logic [31:0] e_rd;
        e_rd = exp_rd(a);
        set_req(p, a, wd, ws);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            seen = (mem_ready != '0);
        end
        rd_o = mem_rdata;
        chk({tag, " latency"}, 32'(n), 32'(WC + 1));
        chk({tag, " ready"}, 32'(mem_ready), 32'(1 << p));
        if (ws == 4'd0) chk({tag, " rdata"}, mem_rdata, e_rd);
        chk({tag, " err"}, 32'(mem_err), 32'(ERR_EXP & !in_rng(a)));
        commit(a, wd, ws);
        lg = p;
        repeat (hold) @(negedge clk);
        mem_valid[p] = 1'b0;
        repeat ((hold > 0) ? 6 : 1) begin
            @(negedge clk);
            chk({tag, " single pulse"}, 32'(mem_ready), 32'd0);
        end
    endtask

    task automatic pair(input logic [31:0] a0, input logic [31:0] wd0, input logic [3:0] ws0,
                        input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] ws1,
                        input string tag);
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [3:0]  ws [2];
        int t [2];
        int n;
        int w;
        a[0] = a0; wd[0] = wd0; ws[0] = ws0;
        a[1] = a1; wd[1] = wd1; ws[1] = ws1;
        t[0] = 0; t[1] = 0;
        w = (lg + 1) % NP;
        set_req(0, a0, wd0, ws0);
        set_req(1, a1, wd1, ws1);
        n = 0;
        while ((t[0] == 0 || t[1] == 0) && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            for (int p = 0; p < NP; p++) begin
                if (mem_ready[p]) begin
                    t[p] = n;
                    chk({tag, " onehot"}, 32'(mem_ready), 32'(1 << p));
                    if (ws[p] == 4'd0) chk({tag, " rdata"}, mem_rdata, exp_rd(a[p]));
                    chk({tag, " err"}, 32'(mem_err), 32'(ERR_EXP & !in_rng(a[p])));
                    commit(a[p], wd[p], ws[p]);
                    mem_valid[p] = 1'b0;
                end
            end
        end
        chk({tag, " winner time"}, 32'(t[w]), 32'(WC + 1));
        chk({tag, " loser time"}, 32'(t[1 - w]), 32'(2 * WC + 3));
        lg = 1 - w;
        @(negedge clk);
        chk({tag, " idle after"}, 32'(mem_ready), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_oor);
        logic [31:0] idx;
        if (allow_oor && $urandom_range(0, 7) == 0) idx = 32'($urandom_range(DEPTH, 4000));
        else idx = 32'($urandom_range(0, DEPTH - 1));
        return {idx[29:0], 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(mem_ready), 32'd0);
        chk("reset rdata", mem_rdata, 32'd0);
        chk("reset err", 32'(mem_err), 32'd0);
        resetn = 1'b1;

        // Contention straight out of reset: port 0 first, port 1 four cycles later.
        pair(32'd40, 32'hA5A5_0001, 4'hF, 32'd44, 32'h5A5A_0002, 4'hF, "contention1");

        for (int i = 0; i < DEPTH; i++) begin
            single(i % NP, 32'(i * 4), $urandom, 4'hF, 0, "preload", rd);
        end

        pair(32'd40, 32'd0, 4'h0, 32'd44, 32'd0, 4'h0, "contention2");

        single(0, 32'd400, 32'h0201_0201, 4'hF, 0, "wr100", rd);
        single(0, 32'd400, 32'd0, 4'h0, 0, "rd100", rd);
        chk("single read value", rd, 32'h0201_0201);

        single(1, 32'd800, 32'h1122_3344, 4'hF, 0, "wr200", rd);
        single(1, 32'd800, 32'hAABB_CCDD, 4'b0101, 0, "bytewr", rd);
        single(1, 32'd800, 32'd0, 4'h0, 0, "rd200", rd);
        chk("byte merge value", rd, 32'h11BB_33DD);

        single(0, 32'd1024, 32'd0, 4'h0, 0, "oor read", rd);
        chk("oor rdata value", rd, 32'd0);
`ifdef PCPI_SHMEM_ERR_RESP_EN
        chk("err_count one", 32'(dut.err_count), 32'd1);
`endif
        single(0, 32'd1024, 32'hFFFF_FFFF, 4'hF, 0, "oor write", rd);
        single(1, 32'd0, 32'd0, 4'h0, 0, "word0 kept", rd);

        // Reset during WAIT abandons the write.
        set_req(0, 32'd64, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        chk("rst mid ready0", 32'(mem_ready), 32'd0);
        resetn = 1'b0;
        mem_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst mid ready1", 32'(mem_ready), 32'd0);
        resetn = 1'b1;
        lg = NP - 1;
        err_cnt_model = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst mid no ready", 32'(mem_ready), 32'd0);
        end
        single(1, 32'd64, 32'd0, 4'h0, 0, "rst word kept", rd);
        single(0, 32'd64, 32'hDEAD_BEEF, 4'hF, 0, "rst rewrite", rd);
        single(1, 32'd64, 32'd0, 4'h0, 0, "rst reread", rd);

        // Valid held through RESP must not be served twice.
        single(0, 32'd128, 32'h0000_0001, 4'hF, 1, "hold valid", rd);
        single(1, 32'd128, 32'd0, 4'h0, 0, "hold readback", rd);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            single($urandom_range(0, NP - 1), rand_addr(1'b1), $urandom, ws, 0, "rand single", rd);
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ws0;
            logic [3:0] ws1;
            ws0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ws1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            pair(rand_addr(1'b1), $urandom, ws0, rand_addr(1'b1), $urandom, ws1, "rand pair");
        end
`ifdef PCPI_SHMEM_ERR_RESP_EN
        chk("err_count final", 32'(dut.err_count), 32'(err_cnt_model));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
